// File: rtl/acpi_pkg.sv
// Shared constants and FSM state encoding for the ACPI demosaic blocks.
package acpi_pkg;
   localparam int ADDRESS = 14;
   localparam int IMG_W   = 128;
   localparam int WIN     = 5;
   localparam int BORDER  = WIN / 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;
endpackage

// File: rtl/acpi_addr_gen.sv
// Window position counters; forms the Bayer read address and the window centre address.
module acpi_addr_gen #(
   parameter int ADDRESS = acpi_pkg::ADDRESS,
   parameter int IMG_W   = acpi_pkg::IMG_W,
   parameter int WIN     = acpi_pkg::WIN
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_start,
   input  logic               row_start,
   input  logic               col_step,
   input  logic               acc,
   input  logic               col_adv,
   output logic [ADDRESS-1:0] bayer_addr,
   output logic [ADDRESS-1:0] center_addr,
   output logic [2:0]         fet_row,
   output logic               last_col,
   output logic               last_row
);
   import acpi_pkg::*;

   localparam int LW   = $clog2(IMG_W);
   localparam int BRD  = WIN / 2;
   localparam int LAST = IMG_W - 1 - BRD;

   // top_row is the frame row of window row 0, so reset state yields address 0
   logic [LW-1:0] top_row;
   logic [LW-1:0] cen_col;
   logic [LW-1:0] fet_col;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         top_row <= '0;
         cen_col <= LW'(BRD);
         fet_col <= '0;
         fet_row <= '0;
      end else if (frame_start) begin
         top_row <= '0;
         cen_col <= LW'(BRD);
         fet_col <= '0;
         fet_row <= '0;
      end else if (row_start) begin
         if (!last_row) top_row <= top_row + 1'b1;
         cen_col <= LW'(BRD);
         fet_col <= '0;
         fet_row <= '0;
      end else if (col_step) begin
         if (!last_col) begin
            cen_col <= cen_col + 1'b1;
            fet_col <= fet_col + 1'b1;
         end
         fet_row <= '0;
      end else if (acc) begin
         if (fet_row == 3'(WIN - 1)) begin
            fet_row <= '0;
            if (col_adv) fet_col <= fet_col + 1'b1;
         end else begin
            fet_row <= fet_row + 3'd1;
         end
      end
   end

   assign bayer_addr  = {top_row + LW'(fet_row), fet_col};
   assign center_addr = {top_row + LW'(BRD), cen_col};
   assign last_col    = (cen_col == LW'(LAST));
   assign last_row    = (top_row == LW'(IMG_W - WIN));
endmodule

// File: rtl/acpi_scan_ctrl.sv
// Scan sequencer: walks the 5x5 window over the frame, issues column-ordered reads
// and hands complete windows to the demosaic datapath.
//   state   | meaning
//   ST_IDLE | waiting for start after reset
//   ST_FILL | fetching 1 or 5 window columns, draining the last pixel
//   ST_WAIT | window complete, win_valid high until win_ack
//   ST_DONE | frame finished, finish high until next start
module acpi_scan_ctrl #(
   parameter int ADDRESS = acpi_pkg::ADDRESS,
   parameter int IMG_W   = acpi_pkg::IMG_W,
   parameter int WIN     = acpi_pkg::WIN
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [ADDRESS-1:0] bayer_addr,
   output logic               bayer_req,
   input  logic               bayer_ready,
   output logic               pix_we,
   output logic [2:0]         pix_row,
   output logic               col_first,
   output logic               win_valid,
   input  logic               win_ack,
   output logic [ADDRESS-1:0] center_addr,
   output logic               finish
);
   import acpi_pkg::*;

   state_t             state;
   logic [2:0]         cols_left;
   logic               issued;
   logic [2:0]         fet_row;
   logic               last_col, last_row;
   logic [ADDRESS-1:0] center_raw;
   logic               accept, col_end, col_adv, last_accept;
   logic               ack, frame_start, row_start, col_step;

   assign bayer_req   = (state == ST_FILL) && !issued;
   assign accept      = bayer_req && bayer_ready;
   assign col_end     = accept && (fet_row == 3'(WIN - 1));
   assign col_adv     = col_end && (cols_left != 3'd1);
   assign last_accept = col_end && (cols_left == 3'd1);
   assign ack         = (state == ST_WAIT) && win_ack;
   assign frame_start = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign row_start   = ack && last_col && !last_row;
   assign col_step    = ack && !last_col;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cols_left <= '0;
         issued    <= 1'b0;
         pix_we    <= 1'b0;
         pix_row   <= '0;
         col_first <= 1'b0;
      end else begin
         pix_we    <= accept;
         col_first <= accept && (cols_left == 3'(WIN));
         if (accept) pix_row <= fet_row;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state     <= ST_FILL;
                  cols_left <= 3'(WIN);
                  issued    <= 1'b0;
               end
            end
            ST_FILL: begin
               if (col_adv) cols_left <= cols_left - 3'd1;
               if (last_accept) issued <= 1'b1;
               // leave only once the final pixel has been presented
               if (issued && pix_we) state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (win_ack) begin
                  issued <= 1'b0;
                  if (!last_col) begin
                     state     <= ST_FILL;
                     cols_left <= 3'd1;
                  end else if (!last_row) begin
                     state     <= ST_FILL;
                     cols_left <= 3'(WIN);
                  end else begin
                     state <= ST_DONE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign win_valid   = (state == ST_WAIT);
   assign finish      = (state == ST_DONE);
   assign center_addr = win_valid ? center_raw : '0;

   acpi_addr_gen #(
      .ADDRESS (ADDRESS),
      .IMG_W   (IMG_W),
      .WIN     (WIN)
   ) u_addr_gen (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .row_start   (row_start),
      .col_step    (col_step),
      .acc         (accept),
      .col_adv     (col_adv),
      .bayer_addr  (bayer_addr),
      .center_addr (center_raw),
      .fet_row     (fet_row),
      .last_col    (last_col),
      .last_row    (last_row)
   );
endmodule

// File: tb/tb_acpi_scan_ctrl.sv
// Bench for acpi_scan_ctrl: scoreboarded read/pixel sequence on a full-size instance,
// frame-end behaviour on a reduced 16x16 instance.
module tb_acpi_scan_ctrl;
   typedef struct {
      int addr;
      int row;
      int cf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [13:0] bayer_addr;
   logic        bayer_req;
   logic        bayer_ready = 1'b1;
   logic        pix_we;
   logic [2:0]  pix_row;
   logic        col_first;
   logic        win_valid;
   logic        win_ack = 1'b0;
   logic [13:0] center_addr;
   logic        finish;

   logic        start_s = 1'b0;
   logic        ack_s = 1'b0;
   logic        ready_s = 1'b1;
   logic [7:0]  addr_s, center_s;
   logic        req_s, we_s, cf_s, valid_s, finish_s;
   logic [2:0]  row_s;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t pend_q[$];
   exp_t me, pe;
   bit   held_v = 1'b0;
   int   held_a = 0;
   bit   stall_en = 1'b0;
   int   mr, mc, n, lat;

   always #5 clk = ~clk;

   acpi_scan_ctrl u_dut (
      .clk(clk), .rst(rst), .start(start), .bayer_addr(bayer_addr), .bayer_req(bayer_req),
      .bayer_ready(bayer_ready), .pix_we(pix_we), .pix_row(pix_row), .col_first(col_first),
      .win_valid(win_valid), .win_ack(win_ack), .center_addr(center_addr), .finish(finish)
   );

   acpi_scan_ctrl #(.ADDRESS(8), .IMG_W(16), .WIN(5)) u_small (
      .clk(clk), .rst(rst), .start(start_s), .bayer_addr(addr_s), .bayer_req(req_s),
      .bayer_ready(ready_s), .pix_we(we_s), .pix_row(row_s), .col_first(cf_s),
      .win_valid(valid_s), .win_ack(ack_s), .center_addr(center_s), .finish(finish_s)
   );

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic push_fill(input int cr, input int cc, input int ncol);
      int first;
      exp_t e;
      first = (ncol == 5) ? cc - 2 : cc + 2;
      for (int c = first; c < first + ncol; c++)
         for (int r = 0; r < 5; r++) begin
            e.addr = (cr - 2 + r) * 128 + c;
            e.row  = r;
            e.cf   = (ncol == 5 && c == first) ? 1 : 0;
            exp_q.push_back(e);
         end
   endtask

   always @(posedge clk) begin
      #1;
      bayer_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   always @(negedge clk) begin
      if (rst) begin
         held_v = 1'b0;
      end else begin
         if (pix_we) begin
            if (pend_q.size() == 0) chk("spurious_pix_we", 1, 0);
            else begin
               pe = pend_q.pop_front();
               chk("pix_row", int'(pix_row), pe.row);
               chk("col_first", int'(col_first), pe.cf);
            end
         end
         if (held_v) begin
            chk("stall_addr_hold", int'(bayer_addr), held_a);
            chk("stall_req_hold", int'(bayer_req), 1);
         end
         if (bayer_req && bayer_ready) begin
            if (exp_q.size() == 0) chk("extra_read", int'(bayer_addr), -1);
            else begin
               me = exp_q.pop_front();
               chk("rd_addr", int'(bayer_addr), me.addr);
               pend_q.push_back(me);
            end
         end
         held_v = bayer_req && !bayer_ready;
         held_a = int'(bayer_addr);
      end
   end

   // acknowledges the current window after d cycles, advances the model, waits for the next one
   task automatic ack_next(input int d, input bit noise, output int l);
      repeat (d) begin
         @(negedge clk);
         chk("win_held", int'(win_valid), 1);
      end
      if (mc < 125) begin
         mc++;
         push_fill(mr, mc, 1);
      end else begin
         mr++;
         mc = 2;
         push_fill(mr, mc, 5);
      end
      @(posedge clk); #1 win_ack = 1'b1;
      @(posedge clk); #1 win_ack = noise; start = noise;
      @(negedge clk);
      chk("win_deassert", int'(win_valid), 0);
      l = 1;
      @(posedge clk); #1 win_ack = 1'b0; start = 1'b0;
      do begin
         @(negedge clk);
         l++;
      end while (!win_valid && l < 400);
      chk("win_timeout", int'(win_valid), 1);
      chk("center_addr", int'(center_addr), mr * 128 + mc);
   endtask

   task automatic start_first(output int cnt);
      mr = 2;
      mc = 2;
      push_fill(2, 2, 5);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         if (cnt == 1) chk("req_cycle1", int'(bayer_req), 1);
      end while (!win_valid && cnt < 400);
   endtask

   initial begin
      int cnt, last, cyc;
      bit fin_next;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", int'(bayer_req), 0);
      chk("rst_addr", int'(bayer_addr), 0);
      chk("rst_pix_we", int'(pix_we), 0);
      chk("rst_pix_row", int'(pix_row), 0);
      chk("rst_col_first", int'(col_first), 0);
      chk("rst_win_valid", int'(win_valid), 0);
      chk("rst_center", int'(center_addr), 0);
      chk("rst_finish", int'(finish), 0);
      @(posedge clk); #1 rst = 1'b0;

      start_first(n);
      chk("first_win_cycle", n, 27);
      chk("first_center", int'(center_addr), 258);
      chk("first_drained", exp_q.size() + pend_q.size(), 0);

      // rest of row 2, with ignored start/ack pulses during fills
      for (int i = 0; i < 123; i++) begin
         ack_next(0, (i % 3) == 0, lat);
         chk("steady_latency", lat, 7);
      end
      chk("row_end_center", int'(center_addr), 381);
      ack_next(0, 1'b0, lat);
      chk("row_change_latency", lat, 27);
      chk("row_change_center", int'(center_addr), 386);

      stall_en = 1'b1;
      for (int i = 0; i < 40; i++) ack_next($urandom_range(0, 10), 1'b0, lat);
      stall_en = 1'b0;

      // asynchronous reset in the middle of a fill
      mc++;
      push_fill(mr, mc, 1);
      @(posedge clk); #1 win_ack = 1'b1;
      @(posedge clk); #1 win_ack = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_req", int'(bayer_req), 0);
      chk("arst_addr", int'(bayer_addr), 0);
      chk("arst_pix_we", int'(pix_we), 0);
      chk("arst_win_valid", int'(win_valid), 0);
      chk("arst_center", int'(center_addr), 0);
      chk("arst_finish", int'(finish), 0);
      exp_q.delete();
      pend_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      start_first(n);
      chk("restart_win_cycle", n, 27);
      chk("restart_center", int'(center_addr), 258);
      for (int i = 0; i < 3; i++) ack_next(1, 1'b0, lat);

      // frame end on the 16x16 instance
      @(posedge clk); #1 start_s = 1'b1;
      @(posedge clk); #1 start_s = 1'b0;
      cnt = 0;
      last = -1;
      cyc = 0;
      fin_next = 1'b0;
      while (!finish_s && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (valid_s) begin
            cnt++;
            last = int'(center_s);
            @(posedge clk); #1 ack_s = 1'b1;
            @(posedge clk); #1 ack_s = 1'b0;
            @(negedge clk);
            fin_next = finish_s;
         end
      end
      chk("frame_windows", cnt, 144);
      chk("frame_last_center", last, 221);
      chk("finish_after_last_ack", int'(fin_next), 1);
      repeat (5) @(negedge clk);
      chk("finish_held", int'(finish_s), 1);
      chk("done_no_req", int'(req_s), 0);
      @(posedge clk); #1 start_s = 1'b1;
      @(posedge clk); #1 start_s = 1'b0;
      @(negedge clk);
      chk("restart_finish_low", int'(finish_s), 0);
      chk("restart_req", int'(req_s), 1);
      chk("restart_addr", int'(addr_s), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/acpi_scan_ctrl.md
# acpi_scan_ctrl

Sequencer for the ACPI demosaic datapath. It walks the 5x5 Bayer window over a 128x128 frame in raster order of window centres and issues column-ordered reads to the Bayer memory. It tells the datapath when each fetched pixel is on `bayer_data` and when a complete window is ready, then asserts `finish` after the last centre has been acknowledged. Row changes are handled here: at the end of a row the window is refilled from column 0 of the next row.

## Interface
- `ADDRESS`, 14, memory address width (`IMG_W*IMG_W` = 16384 words).
- `IMG_W`, 128, image width and height in pixels; power of two.
- `WIN`, 5, window side; border = `WIN/2` = 2.
- `clk` in 1, rising-edge clock.
- `rst` in 1, asynchronous, active-high reset.
- `start` in 1, one-cycle pulse; begins a frame when in IDLE or DONE, ignored otherwise.
- `bayer_addr` out `ADDRESS`, read address; held stable while `bayer_req`=1 and not accepted.
- `bayer_req` out 1, read request.
- `bayer_ready` in 1, memory accepts the request this cycle.
- `pix_we` out 1, `bayer_data` holds the pixel accepted on the previous cycle.
- `pix_row` out 3, window row 0..4 (top..bottom) of the pixel under `pix_we`.
- `col_first` out 1, with `pix_we`: the pixel belongs to the first column of a refill.
- `win_valid` out 1, 5x5 window complete; held until acknowledged.
- `win_ack` in 1, datapath consumed the window.
- `center_addr` out `ADDRESS`, address of the window centre; valid while `win_valid`=1.
- `finish` out 1, frame done; held high in DONE.

## Operation
- Centres cover rows 2..125 and cols 2..125, giving 124x124 = 15376 windows.
- Pixel address = row*`IMG_W` + col, formed by concatenation (no multiplier).
- States:
  - IDLE: on `start`, go to FILL with `fill_cnt`=5, fetch column = centre col − 2, centre = (2,2).
  - FILL: fetch `fill_cnt` columns. Each column is 5 reads, rows centre−2..centre+2, top to bottom. After the final accept, wait for the last `pix_we`, then go to WAIT.
  - WAIT: `win_valid`=1. On `win_ack`:
    - centre col < 125: centre col+1, fetch col+1, `fill_cnt`=1, go to FILL.
    - centre col = 125, row < 125: centre = (row+1, 2), fetch col 0, `fill_cnt`=5, go to FILL.
    - centre = (125,125): go to DONE.
  - DONE: `finish`=1. On `start`, restart as from IDLE.
- `col_first`=1 only for the 5 pixels of the first column of a 5-column refill; the datapath clears its window on it.
- No prefetch while in WAIT: `bayer_req`=0.
- All counters saturate inside their range and never wrap past frame end.

## Timing
- Reset values:
  - `bayer_addr`=0, `bayer_req`=0, `pix_we`=0, `pix_row`=0, `col_first`=0.
  - `win_valid`=0, `center_addr`=0, `finish`=0.
  - State IDLE.
- Handshake: a read is accepted in a cycle with `bayer_req`&`bayer_ready`=1.
  - `pix_we`/`pix_row` assert exactly one cycle after acceptance.
  - The address advances on the acceptance edge.
  - `bayer_ready`=0 holds `bayer_addr` and `bayer_req`.
- `start` on edge 0 → `bayer_req`=1 from cycle 1. With `bayer_ready` always 1:
  - Accepts on cycles 1..25, `pix_we` on cycles 2..26.
  - `win_valid` on cycle 27.
- Steady state: `win_ack` at cycle t → `bayer_req` at t+1, 5 accepts, `win_valid` at t+7.
- `win_valid` deasserts the cycle after `win_ack`=1.
- `win_ack` while `win_valid`=0 is ignored.
- `start` during FILL/WAIT is ignored.
- `rst` at any time returns every output to its reset value within the same cycle (asynchronous) and aborts any outstanding read.

## Structure
- Shared package `acpi_pkg`: `ADDRESS`, `IMG_W`, `WIN`, border constant, FSM state enum (IDLE, FILL, WAIT, DONE).
- The datapath and the ACPI write-back stage import it.
- One sub-module: `acpi_addr_gen`. It holds the centre row/col and fetch col/row counters and forms `bayer_addr` and `center_addr`, driven by advance/refill strobes from the FSM.

## Test plan
- Reset: assert `rst` mid-frame → all outputs 0 immediately; `start` afterwards restarts at `bayer_addr`=0.
- First window, `bayer_ready`=1:
  - Addresses are 0,128,256,384,512,1,129,…,516.
  - `col_first` high for `pix_row` 0..4 of the first column.
  - `win_valid` at cycle 27 with `center_addr`=258.
- Steady state: after the ack of centre 258, the next addresses are 5,133,261,389,517 and `center_addr`=259.
- Row change: after the ack of `center_addr`=381, addresses restart at 128,256,384,512,640, then 129…; next `center_addr`=386.
- Stalls: random `bayer_ready` low and `win_ack` delayed 0–10 cycles:
  - `bayer_addr` stable across stalls.
  - Pixel sequence identical to the no-stall run.
  - `win_valid` held until ack.
- Frame end:
  - Exactly 15376 `win_valid`/`win_ack` pairs.
  - The last `center_addr` is 16125.
  - `finish`=1 the cycle after that ack and stays high until the next `start`.
